// File: rtl/seg7_pkg.sv
// Shared constants, hex-to-segment table and anode index helper for the seven-segment digit driver.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic [7:0] ANODE_OFF = 8'hFF;
    localparam logic [7:0] ANODE_D0  = 8'hFE;

    // Active-low segments {g,f,e,d,c,b,a}, indexed by hex value
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Returns {valid, idx}; valid only when exactly one anode bit is low
    function automatic logic [3:0] onehot_low_idx(input logic [7:0] anode);
        logic [3:0]  r;
        int unsigned n;
        r = '0;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (!anode[k]) begin
                n++;
                r[2:0] = 3'(k);
            end
        end
        r[3] = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/seg7_digit_driver.sv
// Registered anode/cathode driver with frame-aligned shadow load and anti-ghost blanking.
// Optional build macro SEG7_LZ_BLANK_EN enables leading-zero blanking.
module seg7_digit_driver
    import seg7_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned BLANK_W      = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  anode_in,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [7:0]  anode_out,
    output logic [6:0]  cathode,
    output logic        dp_out,
    output logic        frame_start
);

    logic [7:0]         anode_q;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [31:0]        pend_q, pend_d, active_q, active_d;
    logic [7:0]         pend_dp_q, pend_dp_d, active_dp_q, active_dp_d;
    logic               pend_full_q, pend_full_d;
    logic [7:0]         anode_out_q, anode_out_d;
    logic [6:0]         cathode_q, cathode_d;
    logic               dp_out_q, dp_out_d;
    logic               frame_start_q, frame_start_d;

    logic       change, commit, load;
    logic [3:0] sel;
    logic       sel_valid;
    logic [2:0] sel_idx;
    logic [3:0] nibble;
    logic [6:0] seg;
    logic       digit_blank;

    assign change    = (anode_in != anode_q);
    assign commit    = change && (anode_in == ANODE_D0) && pend_full_q;
    assign load      = data_valid && !pend_full_q;
    assign sel       = onehot_low_idx(anode_in);
    assign sel_valid = sel[3];
    assign sel_idx   = sel[2:0];

    // Decode from the next active value so a commit shows on digit 0 without delay
    assign nibble = active_d[{sel_idx, 2'b00} +: 4];

    seg7_hex_decode u_hex_decode (
        .hex_i (nibble),
        .seg_o (seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    logic [7:0] lz_mask_q, lz_mask_d;

    function automatic logic [7:0] lz_mask_of(input logic [31:0] value);
        logic [7:0] m;
        m = '0;
        for (int k = 7; k >= 1; k--) begin
            if (value[4*k +: 4] != 4'h0) break;
            m[k] = 1'b1;
        end
        return m;
    endfunction

    assign lz_mask_d   = commit ? lz_mask_of(pend_q) : lz_mask_q;
    assign digit_blank = lz_mask_d[sel_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lz_mask_q <= 8'hFE;
        else       lz_mask_q <= lz_mask_d;
    end
`else
    assign digit_blank = 1'b0;
`endif

    always_comb begin
        pend_d      = pend_q;
        pend_dp_d   = pend_dp_q;
        pend_full_d = pend_full_q;
        active_d    = active_q;
        active_dp_d = active_dp_q;
        if (commit) begin
            active_d    = pend_q;
            active_dp_d = pend_dp_q;
            pend_full_d = 1'b0;
        end else if (load) begin
            pend_d      = data_in;
            pend_dp_d   = dp_in;
            pend_full_d = 1'b1;
        end

        if (change) begin
            blank_cnt_d = BLANK_W'(BLANK_CYCLES);
        end else if (blank_cnt_q != '0) begin
            blank_cnt_d = blank_cnt_q - BLANK_W'(1);
        end else begin
            blank_cnt_d = '0;
        end
    end

    always_comb begin
        frame_start_d = change && (anode_in == ANODE_D0);
        cathode_d     = SEG_OFF;
        dp_out_d      = 1'b1;
        anode_out_d   = ANODE_OFF;
        if (sel_valid) begin
            cathode_d   = digit_blank ? SEG_OFF : seg;
            dp_out_d    = ~active_dp_d[sel_idx];
            anode_out_d = (blank_cnt_d != '0) ? ANODE_OFF : anode_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            anode_q       <= ANODE_OFF;
            blank_cnt_q   <= '0;
            pend_q        <= '0;
            pend_dp_q     <= '0;
            pend_full_q   <= 1'b0;
            active_q      <= '0;
            active_dp_q   <= '0;
            anode_out_q   <= ANODE_OFF;
            cathode_q     <= SEG_OFF;
            dp_out_q      <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            anode_q       <= anode_in;
            blank_cnt_q   <= blank_cnt_d;
            pend_q        <= pend_d;
            pend_dp_q     <= pend_dp_d;
            pend_full_q   <= pend_full_d;
            active_q      <= active_d;
            active_dp_q   <= active_dp_d;
            anode_out_q   <= anode_out_d;
            cathode_q     <= cathode_d;
            dp_out_q      <= dp_out_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign data_ready  = ~pend_full_q;
    assign anode_out   = anode_out_q;
    assign cathode     = cathode_q;
    assign dp_out      = dp_out_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_digit_driver.sv
// Randomized self-checking bench for seg7_digit_driver, two instances (no blanking / 4-cycle blanking).
module tb_seg7_digit_driver;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  anode_in;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        data_valid;

    logic       r0, d0, f0, r4, d4, f4;
    logic [7:0] a0, a4;
    logic [6:0] c0, c4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seg7_digit_driver #(.BLANK_CYCLES(0), .BLANK_W(3)) u_dut0 (
        .clock (clock), .reset (reset), .anode_in (anode_in), .data_in (data_in),
        .dp_in (dp_in), .data_valid (data_valid), .data_ready (r0), .anode_out (a0),
        .cathode (c0), .dp_out (d0), .frame_start (f0)
    );

    seg7_digit_driver #(.BLANK_CYCLES(4), .BLANK_W(3)) u_dut4 (
        .clock (clock), .reset (reset), .anode_in (anode_in), .data_in (data_in),
        .dp_in (dp_in), .data_valid (data_valid), .data_ready (r4), .anode_out (a4),
        .cathode (c4), .dp_out (d4), .frame_start (f4)
    );

    // Reference model state
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [31:0] m_pend, m_act;
    logic [7:0]  m_pdp, m_adp, m_prev;
    bit          m_pfull;
    int          m_since;
    logic [6:0]  e_cath;
    logic [7:0]  e_an0, e_an4;
    logic        e_dp, e_fs, e_ready;

    function automatic int digit_of(input logic [7:0] a);
        if ($countones(~a) != 1) return -1;
        for (int k = 0; k < 8; k++) if (!a[k]) return k;
        return -1;
    endfunction

    function automatic bit lz_blank(input logic [31:0] v, input int k);
`ifdef SEG7_LZ_BLANK_EN
        return (k > 0) && ((v >> (4 * k)) == 32'd0);
`else
        return (v === 32'hx) && (k < 0);
`endif
    endfunction

    task automatic model_reset();
        m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
        m_pfull = 1'b0; m_prev = 8'hFF; m_since = 1000;
    endtask

    // Advance the model by one clock using the current inputs, then move past the edge
    task automatic cyc();
        bit change;
        int k;
        change = (anode_in !== m_prev);
        if (change && anode_in == 8'hFE && m_pfull) begin
            m_act = m_pend; m_adp = m_pdp; m_pfull = 1'b0;
        end else if (data_valid && !m_pfull) begin
            m_pend = data_in; m_pdp = dp_in; m_pfull = 1'b1;
        end
        e_fs    = change && (anode_in == 8'hFE);
        m_since = change ? 0 : (m_since < 1000 ? m_since + 1 : m_since);
        k       = digit_of(anode_in);
        if (k < 0) begin
            e_cath = 7'h7F; e_dp = 1'b1; e_an0 = 8'hFF; e_an4 = 8'hFF;
        end else begin
            e_cath = lz_blank(m_act, k) ? 7'h7F : seg_tab[4'(m_act >> (4 * k))];
            e_dp   = ~m_adp[k];
            e_an0  = anode_in;
            e_an4  = (m_since < 4) ? 8'hFF : anode_in;
        end
        e_ready = ~m_pfull;
        m_prev  = anode_in;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; anode_in = 8'hFF; data_valid = 1'b0; data_in = '0; dp_in = '0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        model_reset();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; anode_in = 8'hFE; data_valid = 1'b0; data_in = '0; dp_in = '0;
        @(posedge clock); #1;
        if (a0 !== 8'hFF || a4 !== 8'hFF) begin
            errors++; $display("FAIL reset_anode got %h/%h want ff", a0, a4);
        end
        checks++;
        if (c0 !== 7'h7F || c4 !== 7'h7F) begin
            errors++; $display("FAIL reset_cathode got %h/%h want 7f", c0, c4);
        end
        checks++;
        if (d0 !== 1'b1 || d4 !== 1'b1) begin
            errors++; $display("FAIL reset_dp got %b/%b want 1", d0, d4);
        end
        checks++;
        if (r0 !== 1'b1 || r4 !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b/%b want 1", r0, r4);
        end
        checks++;
        if (f0 !== 1'b0 || f4 !== 1'b0) begin
            errors++; $display("FAIL reset_fs got %b/%b want 0", f0, f4);
        end
        checks++;
        do_reset();
    endtask

    task automatic test_rotate();
        logic [6:0] spec_rot [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        data_in = 32'h76543210; dp_in = 8'($urandom); data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 8; k++) begin
                anode_in = ~(8'h01 << k);
                for (int h = 0; h < 5; h++) begin
                    cyc();
                    if (h == 0 && c0 !== spec_rot[k]) begin
                        errors++; $display("FAIL rotate_digit%0d got %h want %h", k, c0, spec_rot[k]);
                    end
                    if (h == 0) checks++;
                    if (c0 !== e_cath || c4 !== e_cath) begin
                        errors++; $display("FAIL rotate_cathode got %h/%h want %h", c0, c4, e_cath);
                    end
                    checks++;
                    if (d0 !== e_dp || d4 !== e_dp) begin
                        errors++; $display("FAIL rotate_dp got %b/%b want %b", d0, d4, e_dp);
                    end
                    checks++;
                    if (a0 !== e_an0 || a4 !== e_an4) begin
                        errors++; $display("FAIL rotate_anode got %h/%h want %h/%h",
                                           a0, a4, e_an0, e_an4);
                    end
                    checks++;
                end
            end
        end
    endtask

    task automatic test_midframe_load();
        for (int k = 0; k < 3; k++) begin anode_in = ~(8'h01 << k); cyc(); end
        anode_in = 8'hFB; data_in = 32'hDEADBEEF; data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        if (r0 !== 1'b0) begin errors++; $display("FAIL midload_ready got %b want 0", r0); end
        checks++;
        if (c0 !== 7'h24) begin errors++; $display("FAIL midload_hold got %h want 24", c0); end
        checks++;
        for (int k = 3; k < 8; k++) begin anode_in = ~(8'h01 << k); cyc(); end
        if (r0 !== 1'b0) begin errors++; $display("FAIL precommit_ready got %b want 0", r0); end
        checks++;
        // Request in the commit cycle must be refused
        anode_in = 8'hFE; data_in = 32'h11111111; data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        if (f0 !== 1'b1 || f4 !== 1'b1) begin
            errors++; $display("FAIL commit_fs got %b/%b want 1", f0, f4);
        end
        checks++;
        if (c0 !== 7'h0E) begin errors++; $display("FAIL commit_digit0 got %h want 0e", c0); end
        checks++;
        if (r0 !== 1'b1) begin errors++; $display("FAIL commit_ready got %b want 1", r0); end
        checks++;
        cyc();
        if (f0 !== 1'b0 || r0 !== 1'b1 || c0 !== e_cath) begin
            errors++; $display("FAIL postcommit got fs=%b rdy=%b cath=%h want 0/1/%h",
                               f0, r0, c0, e_cath);
        end
        checks++;
    endtask

    task automatic test_blank();
        anode_in = 8'hFD; data_in = 32'h76543210; data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        anode_in = 8'hFE;
        for (int h = 0; h < 6; h++) cyc();
        anode_in = 8'hFD;
        for (int h = 0; h < 4; h++) begin
            cyc();
            if (a4 !== 8'hFF || c4 !== 7'h79) begin
                errors++; $display("FAIL blank_cycle%0d got %h/%h want ff/79", h, a4, c4);
            end
            checks++;
        end
        cyc();
        if (a4 !== 8'hFD || a0 !== 8'hFD) begin
            errors++; $display("FAIL blank_release got %h/%h want fd", a4, a0);
        end
        checks++;
    endtask

    task automatic test_invalid();
        logic [7:0] bad [2] = '{8'hFC, 8'hFF};
        for (int i = 0; i < 2; i++) begin
            anode_in = bad[i];
            cyc();
            if (a0 !== 8'hFF || a4 !== 8'hFF || c0 !== 7'h7F || d0 !== 1'b1) begin
                errors++; $display("FAIL invalid_%h got %h/%h/%h/%b want ff/ff/7f/1",
                                   bad[i], a0, a4, c0, d0);
            end
            checks++;
        end
        anode_in = 8'hFB;
        cyc();
        if (a0 !== 8'hFB || c0 !== 7'h24) begin
            errors++; $display("FAIL invalid_recover got %h/%h want fb/24", a0, c0);
        end
        checks++;
    endtask

    task automatic test_reset_midblank();
        anode_in = 8'hFE; cyc();
        data_in = 32'h89ABCDEF; data_valid = 1'b1; cyc();
        data_valid = 1'b0;
        anode_in = 8'hFD; cyc(); cyc();
        reset = 1'b1;
        #1;
        if (a4 !== 8'hFF || c4 !== 7'h7F || d4 !== 1'b1 || r4 !== 1'b1) begin
            errors++; $display("FAIL async_reset got %h/%h/%b/%b want ff/7f/1/1", a4, c4, d4, r4);
        end
        checks++;
        @(posedge clock); #1;
        model_reset();
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            anode_in = ~(8'h01 << k);
            cyc();
            if (c0 !== 7'h40 || c0 !== e_cath) begin
                errors++; $display("FAIL postreset_digit%0d got %h want 40", k, c0);
            end
            checks++;
        end
    endtask

    task automatic test_lz();
`ifdef SEG7_LZ_BLANK_EN
        logic [6:0] want [8] = '{7'h12, 7'h40, 7'h08, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`else
        logic [6:0] want [8] = '{7'h12, 7'h40, 7'h08, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`endif
        data_in = 32'h00000A05; data_valid = 1'b1; cyc();
        data_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            anode_in = ~(8'h01 << k);
            cyc();
            if (c0 !== want[k] || c4 !== want[k]) begin
                errors++; $display("FAIL lz_digit%0d got %h/%h want %h", k, c0, c4, want[k]);
            end
            checks++;
        end
    endtask

    task automatic test_random();
        int hold;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 9) < 8) anode_in = ~(8'h01 << $urandom_range(0, 7));
            else                          anode_in = 8'($urandom);
            hold = $urandom_range(1, 6);
            for (int h = 0; h < hold; h++) begin
                data_valid = ($urandom_range(0, 3) == 0);
                data_in    = $urandom;
                dp_in      = 8'($urandom);
                cyc();
                if (c0 !== e_cath || c4 !== e_cath) begin
                    errors++; $display("FAIL rand_cathode got %h/%h want %h", c0, c4, e_cath);
                end
                checks++;
                if (d0 !== e_dp || d4 !== e_dp) begin
                    errors++; $display("FAIL rand_dp got %b/%b want %b", d0, d4, e_dp);
                end
                checks++;
                if (a0 !== e_an0 || a4 !== e_an4) begin
                    errors++; $display("FAIL rand_anode got %h/%h want %h/%h", a0, a4, e_an0, e_an4);
                end
                checks++;
                if (r0 !== e_ready || r4 !== e_ready) begin
                    errors++; $display("FAIL rand_ready got %b/%b want %b", r0, r4, e_ready);
                end
                checks++;
                if (f0 !== e_fs || f4 !== e_fs) begin
                    errors++; $display("FAIL rand_fs got %b/%b want %b", f0, f4, e_fs);
                end
                checks++;
            end
        end
        data_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_midframe_load();
        test_blank();
        test_invalid();
        test_reset_midblank();
        test_lz();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
